// File: rtl/rv_test_monitor_if.sv
// Bundle of the monitor's snoop, debug-read and dump channels.
// The slave modport is the monitor; the master modport is the core/bench side.
interface rv_test_monitor_if #(
    parameter int XLEN = 64
);
    logic            wb_en;
    logic [4:0]      wb_addr;
    logic [XLEN-1:0] wb_data;
    logic [4:0]      rf_raddr;
    logic [XLEN-1:0] rf_rdata;
    logic            dump_valid;
    logic            dump_ready;
    logic [4:0]      dump_index;
    logic [XLEN-1:0] dump_data;

    modport master (
        output wb_en, wb_addr, wb_data, rf_rdata, dump_ready,
        input  rf_raddr, dump_valid, dump_index, dump_data
    );

    modport slave (
        input  wb_en, wb_addr, wb_data, rf_rdata, dump_ready,
        output rf_raddr, dump_valid, dump_index, dump_data
    );
endinterface

// File: rtl/rv_test_monitor.sv
// Result checker for riscv-tests images: shadows x3/x26/x27 from writeback,
// declares pass/fail on test end or timeout, and dumps all registers on fail.
module rv_test_monitor #(
    parameter int XLEN           = 64,
    parameter int TESTNUM_REG    = 3,
    parameter int END_REG        = 26,
    parameter int PASS_REG       = 27,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                 clk,
    input  logic                 rst,
    rv_test_monitor_if.slave     bus,
    output logic                 done,
    output logic                 pass,
    output logic                 timeout,
    output logic [XLEN-1:0]      fail_testnum,
    output logic [31:0]          cycle_cnt
);

    localparam logic [1:0] ST_RUN  = 2'd0;
    localparam logic [1:0] ST_DUMP = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [4:0]      TN_IDX    = 5'(TESTNUM_REG);
    localparam logic [4:0]      END_IDX   = 5'(END_REG);
    localparam logic [4:0]      PASS_IDX  = 5'(PASS_REG);
    localparam logic [4:0]      LAST_IDX  = 5'd31;
    localparam logic [XLEN-1:0] ONE       = XLEN'(1);
    localparam logic [31:0]     TO_LIMIT  = 32'(TIMEOUT_CYCLES - 1);

    logic [1:0]      state;
    logic [XLEN-1:0] shadow_tn;
    logic [XLEN-1:0] shadow_end;
    logic [XLEN-1:0] shadow_pass;
    logic [4:0]      dump_index;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == '1) ? v : v + 32'd1;
    endfunction

    // End detect looks at the registered shadows, so it lags the x26 capture by one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_RUN;
            shadow_tn    <= '0;
            shadow_end   <= '0;
            shadow_pass  <= '0;
            dump_index   <= '0;
            done         <= 1'b0;
            pass         <= 1'b0;
            timeout      <= 1'b0;
            fail_testnum <= '0;
            cycle_cnt    <= '0;
        end else begin
            case (state)
                ST_RUN: begin
                    cycle_cnt <= sat_inc(cycle_cnt);
                    if (bus.wb_en && bus.wb_addr != 5'd0) begin
                        if (bus.wb_addr == TN_IDX)   shadow_tn   <= bus.wb_data;
                        if (bus.wb_addr == END_IDX)  shadow_end  <= bus.wb_data;
                        if (bus.wb_addr == PASS_IDX) shadow_pass <= bus.wb_data;
                    end
                    if (shadow_end == ONE) begin
                        fail_testnum <= shadow_tn;
                        if (shadow_pass == ONE) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                            pass  <= 1'b1;
                        end else begin
                            state      <= ST_DUMP;
                            dump_index <= '0;
                        end
                    end else if (cycle_cnt == TO_LIMIT) begin
                        timeout      <= 1'b1;
                        fail_testnum <= shadow_tn;
                        state        <= ST_DUMP;
                        dump_index   <= '0;
                    end
                end
                ST_DUMP: begin
                    if (bus.dump_ready) begin
                        if (dump_index == LAST_IDX) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                            pass  <= 1'b0;
                        end else begin
                            dump_index <= dump_index + 5'd1;
                        end
                    end
                end
                ST_DONE: begin
                end
                default: state <= ST_RUN;
            endcase
        end
    end

    // The dump reads the register file through the debug port in the same cycle.
    assign bus.dump_valid = (state == ST_DUMP);
    assign bus.dump_index = dump_index;
    assign bus.rf_raddr   = (state == ST_DUMP) ? dump_index : 5'd0;
    assign bus.dump_data  = bus.rf_rdata;

endmodule
